// File: rtl/rgb_yuv_pipe.sv
// rgb_yuv_pipe: 4-stage handshaked RGB->YUV converter with a per-pixel BT.601 / BT.709 / bypass select.
// Downstream backpressure freezes every stage at once; outputs are rounded, offset and saturated codes.
module rgb_yuv_pipe #(
    parameter int DSIZE = 16,
    parameter int CFRAC = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [DSIZE-1:0] rdata,
    input  logic [DSIZE-1:0] gdata,
    input  logic [DSIZE-1:0] bdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] ydata,
    output logic [DSIZE-1:0] udata,
    output logic [DSIZE-1:0] vdata
);

    localparam int PW = DSIZE + CFRAC + 1;  // signed product width
    localparam int SW = DSIZE + CFRAC + 2;  // sum / rounding width
    localparam int DW = DSIZE + 1;          // signed colour-difference width

    typedef enum logic [1:0] {
        MODE_601 = 2'd0,
        MODE_709 = 2'd1,
        MODE_BYP = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    // Reference coefficients are 15-bit fractions; rescale to CFRAC with round-to-nearest.
    function automatic logic [CFRAC-1:0] kscale(input int k15);
        int v;
        if (CFRAC >= 15) v = k15 * (2 ** (CFRAC - 15));
        else             v = (k15 + 2 ** (14 - CFRAC)) / (2 ** (15 - CFRAC));
        return CFRAC'(v);
    endfunction

    localparam logic [CFRAC-1:0] KR_601 = kscale(9798);
    localparam logic [CFRAC-1:0] KG_601 = kscale(19235);
    localparam logic [CFRAC-1:0] KB_601 = kscale(3736);
    localparam logic [CFRAC-1:0] KU_601 = kscale(16122);
    localparam logic [CFRAC-1:0] KV_601 = kscale(28738);
    localparam logic [CFRAC-1:0] KR_709 = kscale(6966);
    localparam logic [CFRAC-1:0] KG_709 = kscale(23436);
    localparam logic [CFRAC-1:0] KB_709 = kscale(2366);
    localparam logic [CFRAC-1:0] KU_709 = kscale(17659);
    localparam logic [CFRAC-1:0] KV_709 = kscale(20808);

    localparam logic signed [SW-1:0] RND = SW'(1) << (CFRAC - 1);
    localparam logic signed [SW-1:0] OFS = SW'(1) << (DSIZE - 1);

    // Clamp a signed wide value into the unsigned DSIZE-bit code range.
    function automatic logic [DSIZE-1:0] sat(input logic signed [SW-1:0] x);
        if (x[SW-1])               return '0;
        else if (|x[SW-2:DSIZE])   return '1;
        else                       return x[DSIZE-1:0];
    endfunction

    logic stall;
    logic advance;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    // Stage 1: Y products plus delayed components and mode
    logic                 s1_valid;
    logic        [PW-1:0] s1_pr, s1_pg, s1_pb;
    logic [DSIZE-1:0]     s1_r, s1_g, s1_b;
    mode_t                s1_mode;

    // Stage 2: saturated Y and colour differences
    logic                 s2_valid;
    logic [DSIZE-1:0]     s2_y;
    logic signed [DW-1:0] s2_du, s2_dv;
    logic [DSIZE-1:0]     s2_r, s2_g, s2_b;
    mode_t                s2_mode;

    // Stage 3: chroma products
    logic                 s3_valid;
    logic signed [PW-1:0] s3_pu, s3_pv;
    logic [DSIZE-1:0]     s3_y;
    logic [DSIZE-1:0]     s3_r, s3_g, s3_b;
    mode_t                s3_mode;

    mode_t                in_mode;
    logic [CFRAC-1:0]     kr, kg, kb, ku, kv;
    logic signed [SW-1:0] y_round;
    logic [DSIZE-1:0]     y_sat;
    logic signed [DW-1:0] du, dv;
    logic signed [PW-1:0] pu, pv;
    logic signed [SW-1:0] u_round, v_round;
    logic [DSIZE-1:0]     y_out, u_out, v_out;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
        in_mode = (mode == MODE_RSV) ? MODE_601 : mode_t'(mode);
        kr = KR_601;
        kg = KG_601;
        kb = KB_601;
        if (in_mode == MODE_709) begin
            kr = KR_709;
            kg = KG_709;
            kb = KB_709;
        end
    end

    always_comb begin
        ku = KU_601;
        kv = KV_601;
        if (s2_mode == MODE_709) begin
            ku = KU_709;
            kv = KV_709;
        end
    end

    always_comb begin
        y_round = SW'($signed(s1_pr)) + SW'($signed(s1_pg)) + SW'($signed(s1_pb)) + RND;
        y_sat   = sat(y_round >>> CFRAC);
        du      = $signed({1'b0, s1_b}) - $signed({1'b0, y_sat});
        dv      = $signed({1'b0, s1_r}) - $signed({1'b0, y_sat});
    end

    always_comb begin
        pu = PW'(s2_du) * PW'($signed({1'b0, ku}));
        pv = PW'(s2_dv) * PW'($signed({1'b0, kv}));
    end

    always_comb begin
        u_round = SW'(s3_pu) + RND;
        v_round = SW'(s3_pv) + RND;
        y_out   = s3_y;
        u_out   = sat((u_round >>> CFRAC) + OFS);
        v_out   = sat((v_round >>> CFRAC) + OFS);
        if (s3_mode == MODE_BYP) begin
            y_out = s3_r;
            u_out = s3_g;
            v_out = s3_b;
        end
    end

    // Valid chain and output registers; the whole chain moves together or not at all.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            ydata     <= '0;
            udata     <= '0;
            vdata     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            if (s3_valid) begin
                ydata <= y_out;
                udata <= u_out;
                vdata <= v_out;
            end
        end
    end

    // NOTE: internal datapath registers carry no reset; the stage valid bits alone decide what is live.
    always_ff @(posedge clock) begin
        if (advance) begin
            if (in_valid) begin
                s1_pr   <= PW'(kr) * PW'(rdata);
                s1_pg   <= PW'(kg) * PW'(gdata);
                s1_pb   <= PW'(kb) * PW'(bdata);
                s1_r    <= rdata;
                s1_g    <= gdata;
                s1_b    <= bdata;
                s1_mode <= in_mode;
            end
            if (s1_valid) begin
                s2_y    <= y_sat;
                s2_du   <= du;
                s2_dv   <= dv;
                s2_r    <= s1_r;
                s2_g    <= s1_g;
                s2_b    <= s1_b;
                s2_mode <= s1_mode;
            end
            if (s2_valid) begin
                s3_pu   <= pu;
                s3_pv   <= pv;
                s3_y    <= s2_y;
                s3_r    <= s2_r;
                s3_g    <= s2_g;
                s3_b    <= s2_b;
                s3_mode <= s2_mode;
            end
        end
    end

endmodule

// File: tb/tb_rgb_yuv_pipe.sv
// Self-checking bench for rgb_yuv_pipe: DSIZE=8/10/16 instances share one stimulus stream,
// directed vectors with hand-computed codes plus a scoreboard fed by a behavioural model.
module tb_rgb_yuv_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [15:0] r = '0, g = '0, b = '0;

    logic        in_ready8, in_ready10, in_ready16;
    logic        out_valid8, out_valid10, out_valid16;
    logic [7:0]  y8, u8, v8;
    logic [9:0]  y10, u10, v10;
    logic [15:0] y16, u16, v16;
    logic [47:0] got8, got10, got16;

    always #5 clock = ~clock;

    rgb_yuv_pipe #(.DSIZE(8), .CFRAC(15)) u_d8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .mode(mode),
        .rdata(r[7:0]), .gdata(g[7:0]), .bdata(b[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
        .ydata(y8), .udata(u8), .vdata(v8));

    rgb_yuv_pipe #(.DSIZE(10), .CFRAC(15)) u_d10 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready10), .mode(mode),
        .rdata(r[9:0]), .gdata(g[9:0]), .bdata(b[9:0]), .out_valid(out_valid10), .out_ready(out_ready),
        .ydata(y10), .udata(u10), .vdata(v10));

    rgb_yuv_pipe #(.DSIZE(16), .CFRAC(15)) u_d16 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16), .mode(mode),
        .rdata(r), .gdata(g), .bdata(b), .out_valid(out_valid16), .out_ready(out_ready),
        .ydata(y16), .udata(u16), .vdata(v16));

    assign got8  = {16'(y8), 16'(u8), 16'(v8)};
    assign got10 = {16'(y10), 16'(u10), 16'(v10)};
    assign got16 = {y16, u16, v16};

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          sb_on = 1'b0;
    bit          rnd_ready = 1'b0;
    logic [47:0] q8[$], q10[$], q16[$];
    int          n_pop8 = 0, n_pop10 = 0, n_pop16 = 0;
    bit          stall_prev = 1'b0;
    logic [47:0] hold8 = '0, hold16 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int y, input int u, input int v);
        return {16'(y), 16'(u), 16'(v)};
    endfunction

    // Behavioural reference: integer arithmetic, floor shifts, clamp to the code range.
    function automatic logic [47:0] model(input int d, input logic [1:0] m,
                                          input longint rr, input longint gg, input longint bb);
        longint kr, kg, kb, ku, kv, mx, y, u, v;
        if (m == 2'd2) return {16'(rr), 16'(gg), 16'(bb)};
        if (m == 2'd1) begin
            kr = 6966; kg = 23436; kb = 2366; ku = 17659; kv = 20808;
        end else begin
            kr = 9798; kg = 19235; kb = 3736; ku = 16122; kv = 28738;
        end
        mx = (longint'(1) << d) - 1;
        y  = (kr * rr + kg * gg + kb * bb + 16384) >>> 15;
        if (y > mx) y = mx;
        u  = ((ku * (bb - y) + 16384) >>> 15) + (longint'(1) << (d - 1));
        v  = ((kv * (rr - y) + 16384) >>> 15) + (longint'(1) << (d - 1));
        if (u < 0) u = 0;
        if (u > mx) u = mx;
        if (v < 0) v = 0;
        if (v > mx) v = mx;
        return {16'(y), 16'(u), 16'(v)};
    endfunction

    // Scoreboard pops and stall-stability checks, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset && stall_prev) begin
            check("hold_valid8", 64'(out_valid8), 64'(1));
            check("hold_data8", 64'(got8), 64'(hold8));
            check("hold_data16", 64'(got16), 64'(hold16));
        end
        stall_prev = !reset && out_valid8 && !out_ready;
        hold8  = got8;
        hold16 = got16;
        if (!reset && sb_on && out_ready) begin
            if (out_valid8) begin
                if (q8.size() == 0) check("q8_empty", 64'(q8.size()), 64'(1));
                else check("stream8", 64'(got8), 64'(q8.pop_front()));
                n_pop8++;
            end
            if (out_valid10) begin
                if (q10.size() == 0) check("q10_empty", 64'(q10.size()), 64'(1));
                else check("stream10", 64'(got10), 64'(q10.pop_front()));
                n_pop10++;
            end
            if (out_valid16) begin
                if (q16.size() == 0) check("q16_empty", 64'(q16.size()), 64'(1));
                else check("stream16", 64'(got16), 64'(q16.pop_front()));
                n_pop16++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated pixel; checks latency and the DSIZE=8 result against a hand value.
    task automatic send_check(input string tag, input logic [1:0] m, input logic [15:0] rr,
                              input logic [15:0] gg, input logic [15:0] bb, input logic [47:0] exp8);
        int lat = 0;
        mode = m; r = rr; g = gg; b = bb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(4));
        check({tag, "_d8"}, 64'(got8), 64'(exp8));
        check({tag, "_d16"}, 64'(got16), 64'(model(16, m, longint'(rr), longint'(gg), longint'(bb))));
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        tick();
    endtask

    task automatic push(input logic [1:0] m, input logic [15:0] rr, input logic [15:0] gg,
                        input logic [15:0] bb);
        bit acc8, acc10, acc16;
        int guard = 0;
        mode = m; r = rr; g = gg; b = bb; in_valid = 1'b1;
        do begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc8 = in_ready8; acc10 = in_ready10; acc16 = in_ready16;
            @(posedge clock);
            #1;
            if (acc8)  q8.push_back(model(8, m, longint'(rr & 16'h00ff), longint'(gg & 16'h00ff),
                                          longint'(bb & 16'h00ff)));
            if (acc10) q10.push_back(model(10, m, longint'(rr & 16'h03ff), longint'(gg & 16'h03ff),
                                           longint'(bb & 16'h03ff)));
            if (acc16) q16.push_back(model(16, m, longint'(rr), longint'(gg), longint'(bb)));
            guard++;
        end while (!acc8 && guard < 100);
        if (!acc8) check("push_timeout", 64'(acc8), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while ((q8.size() != 0 || q10.size() != 0 || q16.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        check("drain8", 64'(q8.size()), 64'(0));
        check("drain10", 64'(q10.size()), 64'(0));
        check("drain16", 64'(q16.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] alt_exp [4];
        int seen;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_valid", 64'(out_valid8), 64'(0));
        check("rst_data8", 64'(got8), 64'(0));
        check("rst_data16", 64'(got16), 64'(0));
        check("rst_ready", 64'(in_ready8), 64'(1));

        send_check("white601", 2'd0, 16'd255, 16'd255, 16'd255, pk(255, 128, 128));
        send_check("black601", 2'd0, 16'd0, 16'd0, 16'd0, pk(0, 128, 128));
        send_check("red601", 2'd0, 16'd255, 16'd0, 16'd0, pk(76, 91, 255));
        send_check("red709", 2'd1, 16'd255, 16'd0, 16'd0, pk(54, 99, 255));
        send_check("bypass", 2'd2, 16'd10, 16'd20, 16'd30, pk(10, 20, 30));

        // Back-to-back pixels with a different mode each; mode 3 behaves as BT.601.
        alt_exp[0] = pk(76, 91, 255);
        alt_exp[1] = pk(54, 99, 255);
        alt_exp[2] = pk(255, 0, 0);
        alt_exp[3] = pk(76, 91, 255);
        for (int k = 0; k < 4; k++) begin
            mode = 2'(k); r = 16'd255; g = 16'd0; b = 16'd0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("alt%0d_valid", k), 64'(out_valid8), 64'(1));
            check($sformatf("alt%0d_data", k), 64'(got8), 64'(alt_exp[k]));
            tick();
        end
        check("alt_end", 64'(out_valid8), 64'(0));

        // Reset with three pixels in flight discards them all.
        for (int k = 0; k < 3; k++) begin
            mode = 2'd0; r = 16'd255; g = 16'd255; b = 16'd255; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 64'(out_valid8), 64'(0));
        check("midrst_data8", 64'(got8), 64'(0));
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid8) seen++;
        end
        check("midrst_flush", 64'(seen), 64'(0));
        send_check("post_rst", 2'd0, 16'd0, 16'd0, 16'd0, pk(0, 128, 128));

        // out_ready low with an empty output is not a stall; then a real stall, then reset over it.
        out_ready = 1'b0;
        #1;
        check("stall_accept", 64'(in_ready8), 64'(1));
        mode = 2'd2; r = 16'd10; g = 16'd20; b = 16'd30; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1;
        while (!out_valid8 && seen < 10) begin
            tick();
            seen++;
        end
        check("stall_lat", 64'(seen), 64'(4));
        check("stall_ready", 64'(in_ready8), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_data", 64'(got8), 64'(pk(10, 20, 30)));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stall_rst_valid", 64'(out_valid8), 64'(0));
        check("stall_rst_ready", 64'(in_ready8), 64'(1));
        out_ready = 1'b1;
        tick();

        // Random stream under random backpressure, scoreboarded on all three widths.
        sb_on = 1'b1;
        rnd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            push(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        drain();
        check("stream_count8", 64'(n_pop8), 64'(64));

        // Component corners in every mode.
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 8; c++) begin
                push(2'(m), c[2] ? 16'hffff : 16'h0000, c[1] ? 16'hffff : 16'h0000,
                     c[0] ? 16'hffff : 16'h0000);
            end
        end
        drain();
        check("corner_count10", 64'(n_pop10), 64'(96));
        check("corner_count16", 64'(n_pop16), 64'(96));
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
